rom_arbiter: RTL
================

ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter ROM_DEPTH, default 1024, ROM size in 32-bit words (power of two).
REQ-002 Parameter ADDR_W, default 32, byte-address width of both requesters.
REQ-003 clk  input  1  clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 if_req_i  input  1  instruction-fetch read request.
REQ-006 if_addr_i  input  ADDR_W  fetch byte address.
REQ-007 if_gnt_o  output  1  fetch request accepted this cycle.
REQ-008 if_rvalid_o / if_err_o / if_rdata_o  output  1/1/32  fetch response valid, error flag, data.
REQ-009 ls_req_i / ls_addr_i  input  1/ADDR_W  load-unit constant-read request and byte address.
REQ-010 ls_gnt_o / ls_rvalid_o / ls_err_o / ls_rdata_o  output  1/1/1/32  load-unit grant and response.
REQ-011 rom_addr_o  output  ADDR_W  byte address to ROM; ROM returns word rom_addr_o>>2 one cycle later.
REQ-012 rom_data_i  input  32  registered ROM read data.

Function
REQ-013 Requester holds req and addr stable until gnt; gnt is combinational in the request cycle.
REQ-014 At most one gnt per cycle; gnt only to an asserted req.
REQ-015 Granted requester's address drives rom_addr_o that cycle; with no grant rom_addr_o holds its last value.
REQ-016 Response appears exactly one cycle after gnt, on the granted requester's rvalid only, for one cycle.
REQ-017 Back-to-back grants every cycle (throughput 1/cycle), owners may alternate freely.
REQ-018 One-entry owner pipeline register {valid, owner, err} routes rom_data_i to the correct requester.
REQ-019 err=1 if addr[1:0]!=0 or (addr>>2)>=ROM_DEPTH; erroneous requests are still granted, respond with err=1, rdata=0.
REQ-020 Non-responding rdata output is 0; non-addressed rvalid/err are 0.
REQ-021 Contention policy without macro: fixed priority, ls over if.
REQ-022 Lone requester always granted immediately regardless of policy.

Reset
REQ-023 During reset all gnt, rvalid, err, rdata outputs 0; rom_addr_o 0; owner pipeline invalid.
REQ-024 Reset asserted while a response is pending discards it; no rvalid after deassertion until a new grant.
REQ-025 Round-robin pointer resets to "ls preferred".

Configuration
REQ-026 Macro ROM_ARB_RR_EN defined: on contention grant the requester not granted at the last contention, pointer updates only on contended cycles.
REQ-027 Macro absent: fixed ls-over-if priority of REQ-021, no pointer state.

Structure
REQ-028 Package rom_arb_pkg holds owner enum (OWN_IF, OWN_LS), ROM_DEPTH default, response-struct typedef.
REQ-029 One sub-module rr_arb2: 2-input arbiter with pointer, instanced under ROM_ARB_RR_EN, fixed-priority logic otherwise.

Verification
REQ-030 if_req only, addr 0x10 -> if_gnt same cycle, rom_addr_o=0x10, next cycle if_rvalid=1, if_rdata=rom word 4, ls outputs 0.
REQ-031 Both req every cycle for 4 cycles, no macro -> ls granted 4 times, if never; with ROM_ARB_RR_EN -> ls,if,ls,if.
REQ-032 Alternating single requests if@0x0, ls@0x4, if@0x8 consecutive cycles -> responses on if,ls,if consecutive cycles with words 0,1,2.
REQ-033 ls_addr 0x1002 then 0x1000 (ROM_DEPTH 1024) -> both granted; responses err=1, rdata=0.
REQ-034 Grant if@0x20, assert rst_n=0 next cycle before edge -> no if_rvalid after release; first subsequent request serviced normally.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// Shared types for the two-requester ROM arbiter: owner encoding, response pipeline entry, defaults.
package rom_arb_pkg;

  localparam int unsigned ROM_DEPTH_DEF = 1024;
  localparam int unsigned DATA_W        = 32;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
    logic   err;
  } rsp_s;

endpackage

// File: rtl/rr_arb2.sv
// Two-input arbiter (ls vs if); the alternating pointer exists only when RR_EN is set,
// otherwise ls wins every contention.
module rr_arb2 #(
  parameter bit RR_EN = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_ls_i,
  input  logic req_if_i,
  output logic gnt_ls_o,
  output logic gnt_if_o
);

  if (RR_EN) begin : g_rr
    logic pref_ls_q;
    logic pref_ls_d;

    // Pointer moves only on contention, towards the side that just lost.
    always_comb begin
      pref_ls_d = pref_ls_q;
      if (req_ls_i && req_if_i) begin
        pref_ls_d = ~pref_ls_q;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pref_ls_q <= 1'b1;
      end else begin
        pref_ls_q <= pref_ls_d;
      end
    end

    assign gnt_ls_o = req_ls_i & (~req_if_i | pref_ls_q);
  end else begin : g_fixed
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign gnt_ls_o       = req_ls_i;
  end

  assign gnt_if_o = req_if_i & ~gnt_ls_o;

endmodule

// File: rtl/rom_arbiter.sv
// Shares one registered ROM port between instruction fetch and load-unit constant reads.
// Define ROM_ARB_RR_EN for alternating priority on contention; default is ls over if.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned ROM_DEPTH = ROM_DEPTH_DEF,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic              if_err_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              ls_req_i,
  input  logic [ADDR_W-1:0] ls_addr_i,
  output logic              ls_gnt_o,
  output logic              ls_rvalid_o,
  output logic              ls_err_o,
  output logic [DATA_W-1:0] ls_rdata_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_data_i
);

`ifdef ROM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic              gnt_if;
  logic              gnt_ls;
  logic              any_gnt;
  logic [ADDR_W-1:0] sel_addr;
  logic [ADDR_W-1:0] word_idx;
  logic              sel_err;
  logic [ADDR_W-1:0] addr_q;
  rsp_s              pipe_q;
  rsp_s              pipe_d;
  logic              if_own;
  logic              ls_own;

  // Requests are masked while in reset so no grant can leak out.
  rr_arb2 #(
    .RR_EN (RR_EN)
  ) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_ls_i (ls_req_i & rst_n),
    .req_if_i (if_req_i & rst_n),
    .gnt_ls_o (gnt_ls),
    .gnt_if_o (gnt_if)
  );

  assign any_gnt  = gnt_ls | gnt_if;
  assign sel_addr = gnt_ls ? ls_addr_i : if_addr_i;
  assign word_idx = sel_addr >> 2;
  assign sel_err  = (|sel_addr[1:0]) || (word_idx >= ADDR_W'(ROM_DEPTH));

  always_comb begin
    pipe_d       = '0;
    pipe_d.valid = any_gnt;
    pipe_d.owner = gnt_ls ? OWN_LS : OWN_IF;
    pipe_d.err   = any_gnt & sel_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
      if (any_gnt) begin
        addr_q <= sel_addr;
      end
    end
  end

  assign if_gnt_o   = gnt_if;
  assign ls_gnt_o   = gnt_ls;
  assign rom_addr_o = any_gnt ? sel_addr : addr_q;

  // Response steering: only the owner of the pending entry sees rvalid/err/data.
  assign if_own      = pipe_q.valid && (pipe_q.owner == OWN_IF);
  assign ls_own      = pipe_q.valid && (pipe_q.owner == OWN_LS);
  assign if_rvalid_o = if_own;
  assign ls_rvalid_o = ls_own;
  assign if_err_o    = if_own & pipe_q.err;
  assign ls_err_o    = ls_own & pipe_q.err;
  assign if_rdata_o  = (if_own && !pipe_q.err) ? rom_data_i : '0;
  assign ls_rdata_o  = (ls_own && !pipe_q.err) ? rom_data_i : '0;

endmodule
